// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop, LSB first,
// with valid/ready handshakes on both sides. Define ADD_SUB_OVF_EN for the signed overflow port.
module serial_add_sub #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] result,
  output logic            carry
`ifdef ADD_SUB_OVF_EN
  ,
  output logic            overflow
`endif
);

  localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [SIZE-1:0] a_sr;
  logic [SIZE-1:0] b_sr;
  logic            cy;
  logic [CW-1:0]   cnt;
  logic            fa_s;
  logic            fa_c;

  always_comb begin
    fa_s = a_sr[0] ^ b_sr[0] ^ cy;
    fa_c = (a_sr[0] & b_sr[0]) | (cy & (a_sr[0] ^ b_sr[0]));
  end

  // NOTE: state registers use non-blocking assignments so every register in this block
  // samples the pre-edge values; blocking here would let later lines see updated values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the operand shift registers are real flops, not a memory array, so they are
      // cleared on reset like everything else and an aborted operation leaves no residue.
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      cy        <= 1'b0;
      cnt       <= '0;
`ifdef ADD_SUB_OVF_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            a_sr     <= a;
            b_sr     <= sub ? ~b : b;
            cy       <= sub;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          result <= {fa_s, result[SIZE-1:1]};
          cy     <= fa_c;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(SIZE - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            carry     <= fa_c;
`ifdef ADD_SUB_OVF_EN
            // cy is the carry into the MSB on this final bit-cycle.
            overflow  <= cy ^ fa_c;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed vectors, reset abort, result hold,
// randomized operations and back-to-back throughput against an arithmetic reference model.
module tb_serial_add_sub;

  localparam int SIZE = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [SIZE-1:0] a = '0;
  logic [SIZE-1:0] b = '0;
  logic            sub = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [SIZE-1:0] result;
  logic            carry;
`ifdef ADD_SUB_OVF_EN
  logic            overflow;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [SIZE-1:0] res;
    logic            cy;
    logic            ov;
  } exp_t;

  serial_add_sub #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry)
`ifdef ADD_SUB_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views of the operands.
  task automatic model(input logic [SIZE-1:0] ma, input logic [SIZE-1:0] mb, input logic msub,
                       output exp_t e);
    int ua, ub, full, sa, sb, sf;
    ua = int'(ma);
    ub = int'(mb);
    full = msub ? ua - ub : ua + ub;
    e.res = SIZE'(full);
    e.cy = msub ? (ua >= ub) : (full >= (1 << SIZE));
    sa = ma[SIZE-1] ? ua - (1 << SIZE) : ua;
    sb = mb[SIZE-1] ? ub - (1 << SIZE) : ub;
    sf = msub ? sa - sb : sa + sb;
    e.ov = (sf > (1 << (SIZE - 1)) - 1) || (sf < -(1 << (SIZE - 1)));
  endtask

  task automatic wait_done(output exp_t got, output int lat);
    lat = 0;
    while (!out_valid && lat < 4 * SIZE) begin
      tick();
      lat++;
    end
    got.res = result;
    got.cy = carry;
`ifdef ADD_SUB_OVF_EN
    got.ov = overflow;
`else
    got.ov = 1'b0;
`endif
  endtask

  task automatic do_op(input logic [SIZE-1:0] ma, input logic [SIZE-1:0] mb, input logic msub,
                       output exp_t got, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    a = ma;
    b = mb;
    sub = msub;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(got, lat);
  endtask

  task automatic drain;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic compare_op(input string name, input exp_t got, input exp_t exp, input int lat);
    checks++;
    if (lat !== SIZE) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, SIZE);
    end
    checks++;
    if (got.res !== exp.res) begin
      errors++;
      $display("FAIL %s result: got %0d expected %0d", name, got.res, exp.res);
    end
    checks++;
    if (got.cy !== exp.cy) begin
      errors++;
      $display("FAIL %s carry: got %0b expected %0b", name, got.cy, exp.cy);
    end
`ifdef ADD_SUB_OVF_EN
    checks++;
    if (got.ov !== exp.ov) begin
      errors++;
      $display("FAIL %s overflow: got %0b expected %0b", name, got.ov, exp.ov);
    end
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 4'd5;
    b = 4'd6;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset handshake: got in_ready=%0b out_valid=%0b expected 1 0",
               in_ready, out_valid);
    end
    checks++;
    if (result !== '0 || carry !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: got result=%0d carry=%0b expected 0 0", result, carry);
    end
`ifdef ADD_SUB_OVF_EN
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset overflow: got %0b expected 0", overflow);
    end
`endif
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post-reset idle: got in_ready=%0b out_valid=%0b expected 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run;
    a = 4'd15;
    b = 4'd15;
    sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid-run busy: got in_ready=%0b expected 0", in_ready);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || carry !== 1'b0) begin
      errors++;
      $display("FAIL mid-run reset: got in_ready=%0b out_valid=%0b result=%0d carry=%0b expected 1 0 0 0",
               in_ready, out_valid, result, carry);
    end
    repeat (SIZE + 1) tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL aborted op resurfaced: got out_valid=%0b in_ready=%0b expected 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_directed;
    logic [SIZE-1:0] va[5] = '{4'd3, 4'd9, 4'd15, 4'd7, 4'd2};
    logic [SIZE-1:0] vb[5] = '{4'd5, 4'd9, 4'd1, 4'd2, 4'd7};
    logic            vs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [SIZE-1:0] er[5] = '{4'd8, 4'd2, 4'd0, 4'd5, 4'd11};
    logic            ec[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic            eo[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_t got, exp;
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vs[i], got, lat);
      exp.res = er[i];
      exp.cy = ec[i];
      exp.ov = eo[i];
      compare_op($sformatf("directed%0d", i), got, exp, lat);
      drain();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL directed%0d drain: got out_valid=%0b in_ready=%0b expected 0 1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_hold;
    exp_t got, exp, held;
    int lat;
    logic [SIZE-1:0] na, nb;
    logic ns;
    do_op(4'd6, 4'd13, 1'b1, got, lat);
    model(4'd6, 4'd13, 1'b1, exp);
    compare_op("hold_op", got, exp, lat);
    held = got;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = SIZE'($urandom);
      b = SIZE'($urandom);
      sub = 1'($urandom);
      tick();
      checks++;
      if (result !== held.res || carry !== held.cy || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold cycle %0d: got result=%0d carry=%0b in_ready=%0b out_valid=%0b expected %0d %0b 0 1",
                 i, result, carry, in_ready, out_valid, held.res, held.cy);
      end
    end
    na = SIZE'($urandom);
    nb = SIZE'($urandom);
    ns = 1'($urandom);
    a = na;
    b = nb;
    sub = ns;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold release: got out_valid=%0b in_ready=%0b expected 0 1", out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold reaccept: got in_ready=%0b expected 0", in_ready);
    end
    wait_done(got, lat);
    model(na, nb, ns, exp);
    compare_op("hold_next", got, exp, lat);
    drain();
  endtask

  task automatic test_random;
    exp_t got, exp;
    int lat;
    logic [SIZE-1:0] ra, rb;
    logic rs;
    for (int i = 0; i < 20; i++) begin
      ra = SIZE'($urandom);
      rb = SIZE'($urandom);
      rs = 1'($urandom);
      do_op(ra, rb, rs, got, lat);
      model(ra, rb, rs, exp);
      compare_op($sformatf("random%0d a=%0d b=%0d sub=%0b", i, ra, rb, rs), got, exp, lat);
      drain();
    end
  endtask

  task automatic test_back_to_back;
    exp_t q[$];
    exp_t e, got;
    int ops_sent, ops_got, cyc, last;
    logic prev_ov, accepted;
    ops_sent = 0;
    ops_got = 0;
    cyc = 0;
    last = -1;
    prev_ov = 1'b0;
    a = SIZE'($urandom);
    b = SIZE'($urandom);
    sub = 1'($urandom);
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (ops_got < 3 && cyc < 80) begin
      if (out_valid) begin
        got.res = result;
        got.cy = carry;
`ifdef ADD_SUB_OVF_EN
        got.ov = overflow;
`else
        got.ov = 1'b0;
`endif
        e = q.pop_front();
        compare_op($sformatf("b2b%0d", ops_got), got, e, SIZE);
        checks++;
        if (prev_ov !== 1'b0) begin
          errors++;
          $display("FAIL b2b%0d pulse width: got >1 cycle expected 1", ops_got);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last !== SIZE + 2) begin
            errors++;
            $display("FAIL b2b%0d spacing: got %0d expected %0d", ops_got, cyc - last, SIZE + 2);
          end
        end
        last = cyc;
        ops_got++;
      end
      accepted = in_ready && in_valid;
      if (accepted) begin
        model(a, b, sub, e);
        q.push_back(e);
        ops_sent++;
      end
      prev_ov = out_valid;
      tick();
      cyc++;
      if (accepted) begin
        if (ops_sent < 3) begin
          a = SIZE'($urandom);
          b = SIZE'($urandom);
          sub = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (ops_got !== 3) begin
      errors++;
      $display("FAIL b2b count: got %0d expected 3", ops_got);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_directed();
    test_hold();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
